// File: rtl/regfile_pkg.sv
// Shared register-file types and constants used by the writeback controller and its buffer.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LU
   } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that holds long-latency results which lost arbitration to the ALU.
module wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write initiator: arbitrates ALU and long-latency writeback, keeps the busy
// scoreboard for decode and flags hazard violations.
module reg_wb_ctrl #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int LU_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_alu_we,
   input  logic [ADDR_W-1:0]    i_alu_waddr,
   input  logic [DATA_W-1:0]    i_alu_wdata,
   input  logic                 i_lu_valid,
   output logic                 o_lu_ready,
   input  logic [ADDR_W-1:0]    i_lu_waddr,
   input  logic [DATA_W-1:0]    i_lu_wdata,
   input  logic                 i_iss_valid,
   input  logic [ADDR_W-1:0]    i_iss_rd,
   output logic [2**ADDR_W-1:0] o_busy,
   output logic [ADDR_W-1:0]    o_waddr,
   output logic [DATA_W-1:0]    o_wdata,
   output logic                 o_we,
   output logic                 o_err
);
   import regfile_pkg::*;

   localparam int N_REGS = 2 ** ADDR_W;
   localparam int FW     = ADDR_W + DATA_W;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [FW-1:0]     fifo_dout;
   logic              lu_keep;
   logic              alu_keep;
   wb_src_e           sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [N_REGS-1:0] busy_q;
   logic [N_REGS-1:0] busy_d;
   logic              err_q;
   logic              err_d;

   assign o_lu_ready = i_rst_n & ~fifo_full;

   // r0 results complete the handshake but are never buffered or written.
   assign lu_keep  = i_lu_valid & o_lu_ready & (i_lu_waddr != '0);
   assign alu_keep = i_alu_we & (i_alu_waddr != '0);

   wb_fifo #(
      .W     (FW),
      .DEPTH (LU_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({i_lu_waddr, i_lu_wdata}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      sel       = WB_NONE;
      sel_addr  = i_alu_waddr;
      sel_data  = i_alu_wdata;
      fifo_pop  = 1'b0;
      fifo_push = 1'b0;
      if (i_alu_we) begin
         sel       = alu_keep ? WB_ALU : WB_NONE;
         fifo_push = lu_keep;
      end else if (!fifo_empty) begin
         sel       = WB_LU;
         sel_addr  = fifo_dout[FW-1:DATA_W];
         sel_data  = fifo_dout[DATA_W-1:0];
         fifo_pop  = 1'b1;
         fifo_push = lu_keep;
      end else if (lu_keep) begin
         sel      = WB_LU;
         sel_addr = i_lu_waddr;
         sel_data = i_lu_wdata;
      end
   end

   // Clear lands on the same edge that presents the write; a same-cycle issue re-sets the bit.
   always_comb begin
      busy_d = busy_q;
      if (sel == WB_LU) busy_d[sel_addr] = 1'b0;
      if (i_iss_valid && (i_iss_rd != '0)) busy_d[i_iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      err_d = err_q;
      if (i_iss_valid && (i_iss_rd != '0) && busy_q[i_iss_rd]) err_d = 1'b1;
      if (alu_keep && busy_q[i_alu_waddr])                     err_d = 1'b1;
      if (lu_keep && !busy_q[i_lu_waddr])                      err_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_we    <= 1'b0;
         o_waddr <= '0;
         o_wdata <= '0;
         busy_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         o_we   <= (sel != WB_NONE);
         busy_q <= busy_d;
         err_q  <= err_d;
         if (sel != WB_NONE) begin
            o_waddr <= sel_addr;
            o_wdata <= sel_data;
         end
      end
   end

   assign o_busy = busy_q;
   assign o_err  = err_q;
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_reg_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_we;
   logic [4:0]  alu_waddr;
   logic [31:0] alu_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [31:0] busy;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        we;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_wb_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_alu_we    (alu_we),
      .i_alu_waddr (alu_waddr),
      .i_alu_wdata (alu_wdata),
      .i_lu_valid  (lu_valid),
      .o_lu_ready  (lu_ready),
      .i_lu_waddr  (lu_waddr),
      .i_lu_wdata  (lu_wdata),
      .i_iss_valid (iss_valid),
      .i_iss_rd    (iss_rd),
      .o_busy      (busy),
      .o_waddr     (waddr),
      .o_wdata     (wdata),
      .o_we        (we),
      .o_err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alu_we    = 1'b0;
      alu_waddr = '0;
      alu_wdata = '0;
      lu_valid  = 1'b0;
      lu_waddr  = '0;
      lu_wdata  = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
      check({tag, "_we"}, 32'(we), 32'd1);
      check({tag, "_addr"}, 32'(waddr), 32'(a));
      check({tag, "_data"}, wdata, d);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #1 check("rst_ready", 32'(lu_ready), 32'd0);
      cyc(); cyc();
      check("rst_we", 32'(we), 32'd0);
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      #1 check("ready_after_rst", 32'(lu_ready), 32'd1);

      // ALU only
      alu_we = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
      cyc(); idle();
      chk_wr("alu5", 5'd5, 32'hDEADBEEF);
      cyc();
      check("alu5_done", 32'(we), 32'd0);

      // Issue r7, long-latency result three cycles later
      iss_valid = 1'b1; iss_rd = 5'd7;
      cyc(); idle();
      check("busy7_a", busy, 32'h0000_0080);
      cyc();
      check("busy7_b", busy, 32'h0000_0080);
      cyc();
      lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h12;
      #1 check("lu7_ready", 32'(lu_ready), 32'd1);
      cyc(); idle();
      chk_wr("lu7", 5'd7, 32'h12);
      check("busy7_clr", busy, 32'd0);
      check("err_t2", 32'(err), 32'd0);

      // ALU and lu collide
      iss_valid = 1'b1; iss_rd = 5'd9;
      cyc(); idle();
      alu_we = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h333;
      lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h999;
      cyc(); idle();
      chk_wr("col_r3", 5'd3, 32'h333);
      check("col_busy9", busy, 32'h0000_0200);
      cyc();
      chk_wr("col_r9", 5'd9, 32'h999);
      check("col_busy_clr", busy, 32'd0);
      cyc();
      check("col_idle", 32'(we), 32'd0);

      // Backpressure: four ALU cycles with lu held
      iss_valid = 1'b1; iss_rd = 5'd10; cyc();
      iss_rd = 5'd11; cyc();
      iss_rd = 5'd12; cyc();
      idle();
      check("bp_busy", busy, 32'h0000_1C00);
      alu_we = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'h20;
      lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hA0;
      #1 check("bp_rdy0", 32'(lu_ready), 32'd1);
      cyc();
      chk_wr("bp_a20", 5'd20, 32'h20);
      alu_waddr = 5'd21; alu_wdata = 32'h21;
      lu_waddr = 5'd11; lu_wdata = 32'hB0;
      #1 check("bp_rdy1", 32'(lu_ready), 32'd1);
      cyc();
      chk_wr("bp_a21", 5'd21, 32'h21);
      alu_waddr = 5'd22; alu_wdata = 32'h22;
      lu_waddr = 5'd12; lu_wdata = 32'hC0;
      #1 check("bp_rdy2", 32'(lu_ready), 32'd0);
      cyc();
      chk_wr("bp_a22", 5'd22, 32'h22);
      alu_waddr = 5'd23; alu_wdata = 32'h23;
      #1 check("bp_rdy3", 32'(lu_ready), 32'd0);
      cyc();
      chk_wr("bp_a23", 5'd23, 32'h23);
      alu_we = 1'b0;
      #1 check("bp_rdy4", 32'(lu_ready), 32'd0);
      cyc();
      chk_wr("bp_l10", 5'd10, 32'hA0);
      #1 check("bp_rdy5", 32'(lu_ready), 32'd1);
      cyc();
      chk_wr("bp_l11", 5'd11, 32'hB0);
      lu_valid = 1'b0;
      cyc();
      chk_wr("bp_l12", 5'd12, 32'hC0);
      cyc();
      check("bp_idle", 32'(we), 32'd0);
      check("bp_busy_clr", busy, 32'd0);
      check("bp_err", 32'(err), 32'd0);

      // Zero register from both sources
      alu_we = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h1;
      lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h2;
      #1 check("z_ready", 32'(lu_ready), 32'd1);
      cyc(); idle();
      check("z_we0", 32'(we), 32'd0);
      check("z_busy", busy, 32'd0);
      cyc();
      check("z_we1", 32'(we), 32'd0);

      // Double issue, then reset with a full buffer
      iss_valid = 1'b1; iss_rd = 5'd4; cyc();
      cyc(); idle();
      check("haz_err", 32'(err), 32'd1);
      cyc();
      check("haz_sticky", 32'(err), 32'd1);
      iss_valid = 1'b1; iss_rd = 5'd13; cyc();
      iss_rd = 5'd14; cyc();
      idle();
      alu_we = 1'b1; alu_waddr = 5'd21; alu_wdata = 32'h1;
      lu_valid = 1'b1; lu_waddr = 5'd13; lu_wdata = 32'hD;
      cyc();
      alu_waddr = 5'd22;
      lu_waddr = 5'd14; lu_wdata = 32'hE;
      cyc();
      lu_valid = 1'b0; alu_waddr = 5'd23;
      #1 check("full_ready", 32'(lu_ready), 32'd0);
      rst_n = 1'b0;
      idle();
      #1 check("mid_rst_ready", 32'(lu_ready), 32'd0);
      cyc();
      check("mid_rst_we", 32'(we), 32'd0);
      check("mid_rst_busy", busy, 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_waddr", 32'(waddr), 32'd0);
      rst_n = 1'b1;
      #1 check("mid_rst_empty", 32'(lu_ready), 32'd1);
      cyc();
      check("no_stale_we0", 32'(we), 32'd0);
      cyc();
      check("no_stale_we1", 32'(we), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
